// File: rtl/spi_msg_master.sv
// SPI master sending a buffered message of up to F_NUM frames, one cs_n window per frame.
// Define SPI_RX_CAPTURE_EN to store each received frame in rx_buf; otherwise miso is ignored.
//
// state | meaning
// IDLE  | waiting for start, tx_buf writable
// SETUP | cs_n low, MSB on mosi, one half-period before the first sclk edge
// XFER  | 2*F_SIZE sclk half-periods
// GAP   | cs_n high between frames
// DONE  | one-cycle completion pulse
module spi_msg_master #(
  parameter int F_SIZE  = 8,
  parameter int F_NUM   = 4,
  parameter int CLK_DIV = 4,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0,
  parameter int CS_GAP  = 2,
  localparam int AW     = $clog2(F_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW:0]       len,
  output logic              busy,
  output logic              done,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [F_SIZE-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [F_SIZE-1:0] rd_data,
  input  logic              miso,
  output logic              mosi,
  output logic              cs_n,
  output logic              sclk
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HW      = $clog2(2 * F_SIZE);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(CS_GAP - 1);
  localparam logic [HW-1:0] HALF_LOAD = HW'(2 * F_SIZE - 1);
  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(F_NUM);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     div_cnt_q, div_cnt_d;
  logic [HW-1:0]     half_cnt_q, half_cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       len_q, len_d;
  logic [F_SIZE-1:0] shift_q, shift_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic [F_SIZE-1:0] tx_buf_q [F_NUM];
  logic [F_SIZE-1:0] tx_buf_d [F_NUM];
  logic              edge_evt;
  logic              frame_end;
  logic              lead;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    half_cnt_d = half_cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    shift_d    = shift_q;
    sclk_d     = sclk_q;
    tx_buf_d   = tx_buf_q;
    edge_evt   = 1'b0;
    frame_end  = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = CPOL;
        if (wr_en && (int'(wr_addr) < F_NUM)) tx_buf_d[wr_addr] = wr_data;
        if (start) begin
          len_d     = (len > LEN_MAX) ? LEN_MAX : len;
          idx_d     = '0;
          div_cnt_d = DIV_LOAD;
          // read through tx_buf_d so a same-edge write to entry 0 is sent
          shift_d   = tx_buf_d[0];
          state_d   = (len == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (div_cnt_q == '0) begin
          div_cnt_d  = DIV_LOAD;
          half_cnt_d = HALF_LOAD;
          edge_evt   = 1'b1;
          state_d    = XFER;
        end else begin
          div_cnt_d = div_cnt_q - CW'(1);
        end
      end
      XFER: begin
        if (div_cnt_q == '0) begin
          if (half_cnt_q == '0) begin
            div_cnt_d = GAP_LOAD;
            sclk_d    = CPOL;
            frame_end = 1'b1;
            state_d   = GAP;
          end else begin
            half_cnt_d = half_cnt_q - HW'(1);
            div_cnt_d  = DIV_LOAD;
            edge_evt   = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (div_cnt_q == '0) begin
          if (({1'b0, idx_q} + (AW+1)'(1)) < len_q) begin
            idx_d     = idx_q + AW'(1);
            div_cnt_d = DIV_LOAD;
            shift_d   = tx_buf_q[idx_d];
            state_d   = SETUP;
          end else begin
            state_d = DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // odd remaining half count marks a leading edge; the first edge has no shift
    // for CPHA=1 (MSB already out) and the last edge has no shift for CPHA=0
    lead = half_cnt_d[0];
    if (edge_evt) begin
      sclk_d = ~sclk_q;
      if (CPHA ? (lead && (half_cnt_d != HALF_LOAD)) : (!lead && (half_cnt_d != '0)))
        shift_d = {shift_q[F_SIZE-2:0], 1'b0};
    end
    cs_n_d = !((state_d == SETUP) || (state_d == XFER));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      sclk_q     <= CPOL;
      cs_n_q     <= 1'b1;
      tx_buf_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      half_cnt_q <= half_cnt_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      tx_buf_q   <= tx_buf_d;
    end
  end

  assign busy = (state_q == SETUP) || (state_q == XFER) || (state_q == GAP);
  assign done = (state_q == DONE);
  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign mosi = ~cs_n_q & shift_q[F_SIZE-1];

`ifdef SPI_RX_CAPTURE_EN
  logic [F_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic [F_SIZE-1:0] rx_buf_q [F_NUM];
  logic [F_SIZE-1:0] rx_buf_d [F_NUM];

  always_comb begin
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    if (edge_evt && (CPHA ? !lead : lead)) rx_shift_d = {rx_shift_q[F_SIZE-2:0], miso};
    if (frame_end) rx_buf_d[idx_q] = rx_shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift_q <= '0;
      rx_buf_q   <= '{default: '0};
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
    end
  end

  assign rd_data = (int'(rd_addr) < F_NUM) ? rx_buf_q[rd_addr] : '0;
`else
  logic unused_rx;
  assign unused_rx = ^{miso, rd_addr, frame_end};
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_spi_msg_master.sv
// Bench for spi_msg_master: default-mode instance plus a CPOL=1/CPHA=1 instance,
// each with miso looped back to mosi and a sampling slave model on the wires.
module tb_spi_msg_master;

  typedef struct packed {
    logic [2:0]  len;
    logic [31:0] data;
    logic [2:0]  n_frames;
    logic [8:0]  latency;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, wr_en0, busy0, done0, miso0, mosi0, cs_n0, sclk0;
  logic [2:0] len0;
  logic [1:0] wr_addr0, rd_addr0;
  logic [7:0] wr_data0, rd_data0;
  logic       start1, wr_en1, busy1, done1, miso1, mosi1, cs_n1, sclk1;
  logic [2:0] len1;
  logic [1:0] wr_addr1, rd_addr1;
  logic [7:0] wr_data1, rd_data1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign miso0 = mosi0;
  assign miso1 = mosi1;

  spi_msg_master dut0 (
    .clk(clk), .rst(rst), .start(start0), .len(len0), .busy(busy0), .done(done0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .rd_addr(rd_addr0), .rd_data(rd_data0),
    .miso(miso0), .mosi(mosi0), .cs_n(cs_n0), .sclk(sclk0)
  );

  spi_msg_master #(.CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .len(len1), .busy(busy1), .done(done1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rd_addr(rd_addr1), .rd_data(rd_data1),
    .miso(miso1), .mosi(mosi1), .cs_n(cs_n1), .sclk(sclk1)
  );

  // slave models: sample mosi on rising sclk while cs_n is low, log each frame at cs_n rise
  logic [7:0] frames0[$], frames1[$];
  int         bits0[$], bits1[$], lows0[$], lows1[$];
  logic [7:0] s0_shift, s1_shift;
  int         s0_bits, s1_bits, s0_low, s1_low;
  logic       cs_prev0, sclk_prev0, cs_prev1, sclk_prev1;
  int         mosi_viol = 0;
  int         done_cnt0 = 0;

  always @(negedge clk) begin
    if (cs_n0 === 1'b0) begin
      if (cs_prev0 !== 1'b0) begin s0_bits = 0; s0_low = 0; s0_shift = '0; end
      s0_low++;
      if (sclk0 === 1'b1 && sclk_prev0 === 1'b0) begin
        s0_shift = {s0_shift[6:0], mosi0};
        s0_bits++;
      end
    end else if (cs_prev0 === 1'b0) begin
      frames0.push_back(s0_shift); bits0.push_back(s0_bits); lows0.push_back(s0_low);
    end
    if (cs_n1 === 1'b0) begin
      if (cs_prev1 !== 1'b0) begin s1_bits = 0; s1_low = 0; s1_shift = '0; end
      s1_low++;
      if (sclk1 === 1'b1 && sclk_prev1 === 1'b0) begin
        s1_shift = {s1_shift[6:0], mosi1};
        s1_bits++;
      end
    end else if (cs_prev1 === 1'b0) begin
      frames1.push_back(s1_shift); bits1.push_back(s1_bits); lows1.push_back(s1_low);
    end
    if (cs_n0 === 1'b1 && mosi0 !== 1'b0) mosi_viol++;
    if (cs_n1 === 1'b1 && mosi1 !== 1'b0) mosi_viol++;
    if (done0 === 1'b1) done_cnt0++;
    cs_prev0 = cs_n0; sclk_prev0 = sclk0;
    cs_prev1 = cs_n1; sclk_prev1 = sclk1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic write0(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d;
    @(negedge clk); wr_en0 = 1'b0;
  endtask

  task automatic pulse_start0(input logic [2:0] l);
    @(negedge clk); start0 = 1'b1; len0 = l;
    @(posedge clk); #1; start0 = 1'b0;
  endtask

  // posedges after the start-sampling edge until done is seen high
  task automatic wait_done(input bit which, output int lat);
    lat = 0;
    while (((which ? done1 : done0) !== 1'b1) && lat < 2000) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_frames0(input int base, input int n, input logic [31:0] d);
    logic [31:0] dv;
    dv = d;
    check("frame_count", frames0.size() - base, n);
    for (int i = 0; i < n && (base + i) < frames0.size(); i++) begin
      check($sformatf("frame_byte[%0d]", i), frames0[base+i], dv[31-8*i -: 8]);
      check($sformatf("frame_bits[%0d]", i), bits0[base+i], 8);
      check($sformatf("cs_low_cycles[%0d]", i), lows0[base+i], 68);
    end
  endtask

  vec_t vecs[5];

  initial begin
    int          lat, base, dbase;
    logic [31:0] d;

    vecs[0] = '{len: 3'd4, data: 32'h66706761, n_frames: 3'd4, latency: 9'd280};
    vecs[1] = '{len: 3'd2, data: 32'h00FF1234, n_frames: 3'd2, latency: 9'd140};
    vecs[2] = '{len: 3'd7, data: 32'h817EC33C, n_frames: 3'd4, latency: 9'd280};
    vecs[3] = '{len: 3'd1, data: 32'h5A000000, n_frames: 3'd1, latency: 9'd70};
    vecs[4] = '{len: 3'd0, data: 32'hDEADBEEF, n_frames: 3'd0, latency: 9'd0};

    rst = 1'b1;
    start0 = 0; len0 = 0; wr_en0 = 0; wr_addr0 = 0; wr_data0 = 0; rd_addr0 = 0;
    start1 = 0; len1 = 0; wr_en1 = 0; wr_addr1 = 0; wr_data1 = 0; rd_addr1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n0", cs_n0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_sclk0", sclk0, 0);
    check("rst_mosi0", mosi0, 0);
    check("rst_sclk1_cpol1", sclk1, 1);
    check("rst_cs_n1", cs_n1, 1);
    check("rst_rd_data0", rd_data0, 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      d = vecs[v].data;
      for (int a = 0; a < 4; a++) write0(2'(a), d[31-8*a -: 8]);
      base = frames0.size();
      pulse_start0(vecs[v].len);
      check("cs_n_after_start", cs_n0, (vecs[v].n_frames != 0) ? 32'd0 : 32'd1);
      check("busy_after_start", busy0, (vecs[v].n_frames != 0) ? 32'd1 : 32'd0);
      wait_done(1'b0, lat);
      check("done_latency", lat, vecs[v].latency);
      check("busy_at_done", busy0, 0);
      @(posedge clk); #1;
      check("done_one_cycle", done0, 0);
      check_frames0(base, vecs[v].n_frames, d);
`ifdef SPI_RX_CAPTURE_EN
      for (int i = 0; i < vecs[v].n_frames; i++) begin
        rd_addr0 = 2'(i); #1;
        check($sformatf("rx_data[%0d]", i), rd_data0, d[31-8*i -: 8]);
      end
`else
      rd_addr0 = 2'd0; #1;
      check("rd_data_tied", rd_data0, 0);
`endif
    end

    // reset in the middle of the third frame
    for (int a = 0; a < 4; a++) write0(2'(a), 8'hC1 + 8'(a));
    base = frames0.size();
    pulse_start0(3'd4);
    repeat (150) @(posedge clk);
    #2;
    check("pre_rst_cs_n", cs_n0, 0);
    check("pre_rst_frames", frames0.size() - base, 2);
    #1 rst = 1'b1;
    #1;
    check("midrst_cs_n", cs_n0, 1);
    check("midrst_busy", busy0, 0);
    check("midrst_sclk", sclk0, 0);
    check("midrst_mosi", mosi0, 0);
    check("midrst_done", done0, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_addr0 = 2'(i); #1;
      check($sformatf("rx_cleared[%0d]", i), rd_data0, 0);
    end
    base = frames0.size();
    pulse_start0(3'd2);
    wait_done(1'b0, lat);
    check("post_rst_latency", lat, 140);
    @(posedge clk); #1;
    check_frames0(base, 2, 32'h00000000);

    // start and write while busy are both ignored
    d = 32'h11223344;
    for (int a = 0; a < 4; a++) write0(2'(a), d[31-8*a -: 8]);
    base = frames0.size();
    dbase = done_cnt0;
    pulse_start0(3'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) begin
        start0 = 1'b1; len0 = 3'd4; wr_en0 = 1'b1; wr_addr0 = 2'd1; wr_data0 = 8'hEE;
      end else begin
        start0 = 1'b0; wr_en0 = 1'b0;
      end
      @(posedge clk); #1;
    end
    wait_done(1'b0, lat);
    check("busy_start_latency", lat + 20, 140);
    repeat (300) @(posedge clk);
    #1;
    check("single_done_pulse", done_cnt0 - dbase, 1);
    check("idle_after_ignored_start", busy0, 0);
    check_frames0(base, 2, d);
    base = frames0.size();
    pulse_start0(3'd2);
    wait_done(1'b0, lat);
    @(posedge clk); #1;
    check_frames0(base, 2, d);

    // write and start on the same edge: new data goes out
    base = frames0.size();
    @(negedge clk);
    wr_en0 = 1'b1; wr_addr0 = 2'd0; wr_data0 = 8'h9C; start0 = 1'b1; len0 = 3'd1;
    @(posedge clk); #1;
    wr_en0 = 1'b0; start0 = 1'b0;
    wait_done(1'b0, lat);
    check("same_edge_latency", lat, 70);
    @(posedge clk); #1;
    check_frames0(base, 1, 32'h9C000000);

    // CPOL=1, CPHA=1 single frame
    @(negedge clk); wr_en1 = 1'b1; wr_addr1 = 2'd0; wr_data1 = 8'hA5;
    @(negedge clk); wr_en1 = 1'b0;
    check("m3_sclk_idle", sclk1, 1);
    base = frames1.size();
    @(negedge clk); start1 = 1'b1; len1 = 3'd1;
    @(posedge clk); #1; start1 = 1'b0;
    check("m3_cs_n_low", cs_n1, 0);
    wait_done(1'b1, lat);
    check("m3_latency", lat, 70);
    @(posedge clk); #1;
    check("m3_frame_count", frames1.size() - base, 1);
    if (frames1.size() > base) begin
      check("m3_frame_byte", frames1[base], 8'hA5);
      check("m3_rising_edges", bits1[base], 8);
      check("m3_cs_low_cycles", lows1[base], 68);
    end
    check("m3_sclk_after", sclk1, 1);
`ifdef SPI_RX_CAPTURE_EN
    rd_addr1 = 2'd0; #1;
    check("m3_rx_data", rd_data1, 8'hA5);
`else
    rd_addr1 = 2'd0; #1;
    check("m3_rd_data_tied", rd_data1, 0);
`endif

    check("mosi_low_when_cs_high", mosi_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
